apb_cp_if: RTL and testbench
============================

APB_CP_IF -- requirements
Module: apb_cp_if

Interface
REQ-001 Parameters: none; address map and widths are fixed.
REQ-002 iClk  in  1  sole clock; all state changes on its rising edge.
REQ-003 iRsn  in  1  reset, asynchronous, active-low.
REQ-004 iPsel/iPenable/iPwrite  in  1 each  APB3 setup/access/direction.
REQ-005 iPaddr  in  16  byte address; iPwdata  in  32  write data.
REQ-006 oPrdata  out  32; oPready  out  1; oPslverr  out  1.
REQ-007 oStCp  out  1  one-cycle start pulse to cipher controller; oCpByteSize  out  12  payload length in bytes.
REQ-008 iCpDone  in  1  one-cycle completion pulse from cipher controller.
REQ-009 oWrEn_CpInBuf  out  1; oWdSel_CpInBuf  out  4; oWrAddr_CpInBuf  out  7; oWrDt_CpInBuf  out  128  input-buffer write port.
REQ-010 oRdEn_CpOutBuf  out  1; oRdAddr_CpOutBuf  out  7; iRdDt_CpOutBuf  in  128  output-buffer read port, data valid the cycle after oRdEn_CpOutBuf.

Function
REQ-011 The address map SHALL be: 0x0000 CTRL (W, bit0 start); 0x0004 STATUS (R bit0 busy, bit1 done; W1C bit1); 0x0008 BYTE_SIZE (RW [11:0]); 0x0800-0x0FFF InBuf window (WO); 0x1000-0x17FF OutBuf window (RO).
REQ-012 Window decode SHALL be line = iPaddr[10:4], word = iPaddr[3:2]; word k occupies bits [32k+31:32k], so byte 0 sits in [7:0].
REQ-013 An InBuf write SHALL assert oWrEn_CpInBuf for exactly the access cycle, with oWdSel_CpInBuf = one-hot(word), oWrAddr_CpInBuf = line, and iPwdata replicated to all four words of oWrDt_CpInBuf.
REQ-014 Register reads/writes and InBuf writes SHALL complete with zero wait states: oPready = 1 in the first access cycle.
REQ-015 An OutBuf read SHALL use FSM IDLE -> RD_REQ -> RD_WAIT -> IDLE:
  - first access cycle: oRdEn_CpOutBuf = 1, oRdAddr_CpOutBuf = line, oPready = 0
  - RD_REQ: capture word of iRdDt_CpOutBuf, oPready = 0
  - RD_WAIT: oPready = 1 with captured data
  - total two wait states.
REQ-016 A CTRL write with bit0 = 1 while not busy SHALL pulse oStCp one cycle after the access cycle and set busy in that same cycle.
REQ-017 iCpDone SHALL clear busy and set done; done stays set until written 1 at STATUS bit1.
REQ-018 BYTE_SIZE writes SHALL update oCpByteSize at the next edge; any value > 0x7FF SHALL be rejected with oPslverr and no update.
REQ-019 While busy, these SHALL be rejected with oPslverr = 1, oPready = 1, and no side effect: CTRL start, BYTE_SIZE write, InBuf write, OutBuf read.
REQ-020 If iCpDone and a CTRL start land in the same cycle, busy is still 1 in that cycle, so the start SHALL be rejected per REQ-019.
REQ-021 Unmapped addresses, writes to RO space, and reads of WO space SHALL complete with zero wait states, oPslverr = 1 and oPrdata = 0.
REQ-022 Outside a completing access cycle, oPready, oPslverr and oPrdata SHALL be 0.

Reset
REQ-023 On iRsn low, the block SHALL immediately clear all outputs, busy, done and BYTE_SIZE to 0 and return the FSM to IDLE.
REQ-024 On reset, an OutBuf read in flight SHALL be abandoned without oPready.

Verification
REQ-025 Write 0x0010 to BYTE_SIZE and 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C to 0x0800-0x080C -> four InBuf writes at line 0 with WdSel 1, 2, 4, 8; oCpByteSize = 0x010.
REQ-026 Write CTRL = 1 -> oStCp high for one cycle, STATUS reads 0x1; pulse iCpDone -> STATUS reads 0x2; write 0x2 to STATUS -> STATUS reads 0x0.
REQ-027 With OutBuf line 3 = 0xDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, read 0x1038 -> oRdAddr_CpOutBuf = 3, two wait states, oPrdata = 0xCCCCCCCC.
REQ-028 While busy, write 0x0800 and CTRL = 1 -> oPslverr = 1, no oWrEn_CpInBuf, no oStCp; BYTE_SIZE write of 0x800 -> oPslverr = 1 and value unchanged.
REQ-029 Assert iRsn low during RD_REQ -> oPready never rises, all outputs 0 immediately; after release, a read of 0x0008 returns 0.

Source files
------------

// File: rtl/apb_cp_if.sv
// rtl/apb_cp_if.sv - APB3 slave fronting the cipher controller and its input/output buffers
module apb_cp_if (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iPsel,
  input  logic         iPenable,
  input  logic         iPwrite,
  input  logic [15:0]  iPaddr,
  input  logic [31:0]  iPwdata,
  output logic [31:0]  oPrdata,
  output logic         oPready,
  output logic         oPslverr,
  output logic         oStCp,
  output logic [11:0]  oCpByteSize,
  input  logic         iCpDone,
  output logic         oWrEn_CpInBuf,
  output logic [3:0]   oWdSel_CpInBuf,
  output logic [6:0]   oWrAddr_CpInBuf,
  output logic [127:0] oWrDt_CpInBuf,
  output logic         oRdEn_CpOutBuf,
  output logic [6:0]   oRdAddr_CpOutBuf,
  input  logic [127:0] iRdDt_CpOutBuf
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_REQ  = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] ADDR_CTRL   = 16'h0000;
  localparam logic [15:0] ADDR_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_SIZE   = 16'h0008;
  localparam logic [4:0]  INBUF_PAGE  = 5'b00001;  // 0x0800-0x0FFF
  localparam logic [4:0]  OUTBUF_PAGE = 5'b00010;  // 0x1000-0x17FF
  localparam logic [31:0] SIZE_MAX    = 32'h0000_07FF;

  state_t       state_q, state_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         stcp_q, stcp_d;
  logic [11:0]  byte_size_q, byte_size_d;
  logic [1:0]   word_q, word_d;
  logic [31:0]  rd_data_q, rd_data_d;

  logic         access;
  logic         sel_ctrl, sel_status, sel_size, sel_inbuf, sel_outbuf;
  logic         size_ok;
  logic [6:0]   line;
  logic [1:0]   word;

  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic         wr_en;
  logic [3:0]   wd_sel;
  logic [6:0]   wr_addr;
  logic [127:0] wr_dt;
  logic         rd_en;
  logic [6:0]   rd_addr;

  // Decode the current APB access into register/window selects and buffer coordinates
  always_comb begin
    access     = iPsel & iPenable;
    sel_ctrl   = (iPaddr == ADDR_CTRL);
    sel_status = (iPaddr == ADDR_STATUS);
    sel_size   = (iPaddr == ADDR_SIZE);
    sel_inbuf  = (iPaddr[15:11] == INBUF_PAGE);
    sel_outbuf = (iPaddr[15:11] == OUTBUF_PAGE);
    size_ok    = (iPwdata <= SIZE_MAX);
    line       = iPaddr[10:4];
    word       = iPaddr[3:2];
  end

  // Next-state, register side effects and bus/buffer strobes
  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = done_q;
    stcp_d      = 1'b0;
    byte_size_d = byte_size_q;
    word_d      = word_q;
    rd_data_d   = rd_data_q;
    prdata      = 32'h0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    wr_en       = 1'b0;
    wd_sel      = 4'h0;
    wr_addr     = 7'h0;
    wr_dt       = 128'h0;
    rd_en       = 1'b0;
    rd_addr     = 7'h0;

    // Completion ends the job; a start accepted in the same cycle overrides below,
    // but acceptance needs busy_q == 0, so a busy engine always rejects that start.
    if (iCpDone) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (access) begin
          if (iPwrite) begin
            if (sel_ctrl) begin
              pready = 1'b1;
              if (iPwdata[0]) begin
                if (busy_q) begin
                  pslverr = 1'b1;
                end else begin
                  stcp_d = 1'b1;
                  busy_d = 1'b1;
                end
              end
            end else if (sel_status) begin
              pready = 1'b1;
              // A completion landing with the clear keeps done set
              if (iPwdata[1] && !iCpDone) begin
                done_d = 1'b0;
              end
            end else if (sel_size) begin
              pready = 1'b1;
              if (busy_q || !size_ok) begin
                pslverr = 1'b1;
              end else begin
                byte_size_d = iPwdata[11:0];
              end
            end else if (sel_inbuf) begin
              pready = 1'b1;
              if (busy_q) begin
                pslverr = 1'b1;
              end else begin
                wr_en   = 1'b1;
                wd_sel  = 4'b0001 << word;
                wr_addr = line;
                wr_dt   = {4{iPwdata}};
              end
            end else begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end
          end else begin
            if (sel_status) begin
              pready = 1'b1;
              prdata = {30'h0, done_q, busy_q};
            end else if (sel_size) begin
              pready = 1'b1;
              prdata = {20'h0, byte_size_q};
            end else if (sel_outbuf) begin
              if (busy_q) begin
                pready  = 1'b1;
                pslverr = 1'b1;
              end else begin
                rd_en   = 1'b1;
                rd_addr = line;
                word_d  = word;
                state_d = ST_RD_REQ;
              end
            end else begin
              pready  = 1'b1;
              pslverr = 1'b1;
            end
          end
        end
      end

      ST_RD_REQ: begin
        // Buffer data is valid this cycle; keep only the addressed word
        case (word_q)
          2'd0:    rd_data_d = iRdDt_CpOutBuf[31:0];
          2'd1:    rd_data_d = iRdDt_CpOutBuf[63:32];
          2'd2:    rd_data_d = iRdDt_CpOutBuf[95:64];
          default: rd_data_d = iRdDt_CpOutBuf[127:96];
        endcase
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (access) begin
          pready = 1'b1;
          prdata = rd_data_q;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, status flags, size register and captured read word
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stcp_q      <= 1'b0;
      byte_size_q <= 12'h0;
      word_q      <= 2'd0;
      rd_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      stcp_q      <= stcp_d;
      byte_size_q <= byte_size_d;
      word_q      <= word_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Bus-derived outputs are held low while reset is asserted, even with a live bus
  always_comb begin
    oPrdata           = iRsn ? prdata  : 32'h0;
    oPready           = iRsn & pready;
    oPslverr          = iRsn & pslverr;
    oWrEn_CpInBuf     = iRsn & wr_en;
    oWdSel_CpInBuf    = iRsn ? wd_sel  : 4'h0;
    oWrAddr_CpInBuf   = iRsn ? wr_addr : 7'h0;
    oWrDt_CpInBuf     = iRsn ? wr_dt   : 128'h0;
    oRdEn_CpOutBuf    = iRsn & rd_en;
    oRdAddr_CpOutBuf  = iRsn ? rd_addr : 7'h0;
    oStCp             = stcp_q;
    oCpByteSize       = byte_size_q;
  end

endmodule

// File: tb/tb_apb_cp_if.sv
// tb/tb_apb_cp_if.sv - scoreboard bench for apb_cp_if with randomized APB traffic
module tb_apb_cp_if;

  logic         iClk = 1'b0;
  logic         iRsn = 1'b0;
  logic         iPsel = 1'b0, iPenable = 1'b0, iPwrite = 1'b0;
  logic [15:0]  iPaddr = 16'h0;
  logic [31:0]  iPwdata = 32'h0;
  logic [31:0]  oPrdata;
  logic         oPready, oPslverr, oStCp;
  logic [11:0]  oCpByteSize;
  logic         iCpDone = 1'b0;
  logic         oWrEn_CpInBuf;
  logic [3:0]   oWdSel_CpInBuf;
  logic [6:0]   oWrAddr_CpInBuf;
  logic [127:0] oWrDt_CpInBuf;
  logic         oRdEn_CpOutBuf;
  logic [6:0]   oRdAddr_CpOutBuf;
  logic [127:0] iRdDt_CpOutBuf = 128'h0;

  apb_cp_if dut (
    .iClk(iClk), .iRsn(iRsn), .iPsel(iPsel), .iPenable(iPenable), .iPwrite(iPwrite),
    .iPaddr(iPaddr), .iPwdata(iPwdata), .oPrdata(oPrdata), .oPready(oPready),
    .oPslverr(oPslverr), .oStCp(oStCp), .oCpByteSize(oCpByteSize), .iCpDone(iCpDone),
    .oWrEn_CpInBuf(oWrEn_CpInBuf), .oWdSel_CpInBuf(oWdSel_CpInBuf),
    .oWrAddr_CpInBuf(oWrAddr_CpInBuf), .oWrDt_CpInBuf(oWrDt_CpInBuf),
    .oRdEn_CpOutBuf(oRdEn_CpOutBuf), .oRdAddr_CpOutBuf(oRdAddr_CpOutBuf),
    .iRdDt_CpOutBuf(iRdDt_CpOutBuf)
  );

  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] rdata; logic err; int waits; } resp_t;
  typedef struct { logic [3:0] sel; logic [6:0] addr; logic [127:0] dt; } wr_t;

  resp_t       exp_q[$];
  wr_t         wr_q[$];
  logic [6:0]  rd_q[$];
  int          exp_stcp = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  // reference model state
  bit          m_busy = 0;
  bit          m_done = 0;
  logic [31:0] m_bs = 32'h0;
  logic [31:0] mem [512];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // output buffer: data appears the cycle after the read enable, garbage otherwise
  always @(posedge iClk) begin
    if (oRdEn_CpOutBuf)
      iRdDt_CpOutBuf <= {mem[{oRdAddr_CpOutBuf, 2'd3}], mem[{oRdAddr_CpOutBuf, 2'd2}],
                         mem[{oRdAddr_CpOutBuf, 2'd1}], mem[{oRdAddr_CpOutBuf, 2'd0}]};
    else
      iRdDt_CpOutBuf <= {$urandom, $urandom, $urandom, $urandom};
  end

  // monitor: pops expectations whenever the DUT presents a response or strobe
  initial begin
    int    cyc;
    resp_t e;
    wr_t   w;
    logic [6:0] ra;
    cyc = 0;
    forever begin
      @(negedge iClk);
      if (!iRsn) begin
        cyc = 0;
      end else begin
        if (iPsel && iPenable && oPready) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL resp_unexpected: got completion at %0h expected none", iPaddr);
          end else begin
            e = exp_q.pop_front();
            chk("prdata", 128'(oPrdata), 128'(e.rdata));
            chk("pslverr", 128'(oPslverr), 128'(e.err));
            chk("wait_states", 128'(cyc), 128'(e.waits));
          end
          cyc = 0;
        end else begin
          if (iPsel && iPenable) cyc++;
          chk("idle_bus_outputs", {94'h0, oPready, oPslverr, oPrdata}, 128'h0);
        end
        if (oWrEn_CpInBuf) begin
          if (wr_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL inbuf_unexpected: got write line %0h expected none", oWrAddr_CpInBuf);
          end else begin
            w = wr_q.pop_front();
            chk("inbuf_wdsel", 128'(oWdSel_CpInBuf), 128'(w.sel));
            chk("inbuf_addr", 128'(oWrAddr_CpInBuf), 128'(w.addr));
            chk("inbuf_data", oWrDt_CpInBuf, w.dt);
          end
        end
        if (oRdEn_CpOutBuf) begin
          if (rd_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL outbuf_unexpected: got read line %0h expected none", oRdAddr_CpOutBuf);
          end else begin
            ra = rd_q.pop_front();
            chk("outbuf_addr", 128'(oRdAddr_CpOutBuf), 128'(ra));
          end
        end
        if (oStCp) begin
          n_cmp++;
          if (exp_stcp == 0) begin
            n_err++;
            $display("FAIL stcp_unexpected: got pulse expected none");
          end else begin
            exp_stcp--;
          end
        end
      end
    end
  end

  task automatic apb(input logic [15:0] a, input bit wr, input logic [31:0] d, input bit done_acc);
    bit rdy;
    int n;
    @(posedge iClk); #1;
    iPsel = 1'b1; iPenable = 1'b0; iPwrite = wr; iPaddr = a; iPwdata = d;
    @(posedge iClk); #1;
    iPenable = 1'b1; iCpDone = done_acc;
    rdy = 0; n = 0;
    while (!rdy && n < 10) begin
      @(negedge iClk);
      rdy = oPready;
      @(posedge iClk); #1;
      iCpDone = 1'b0;
      n++;
    end
    if (!rdy) begin
      n_cmp++; n_err++;
      $display("FAIL apb_timeout: got no pready at %0h expected completion", a);
    end
    iPsel = 1'b0; iPenable = 1'b0;
  endtask

  // model computes the expected response from the register/window rules, then drives the access
  task automatic issue(input logic [15:0] a, input bit wr, input logic [31:0] d, input bit done_acc);
    resp_t e;
    wr_t   w;
    int    line, word;
    bit    in_win, out_win;
    e.rdata = 0; e.err = 0; e.waits = 0;
    line    = (int'(a) % 2048) / 16;
    word    = (int'(a) % 16) / 4;
    in_win  = (a >= 16'h0800 && a <= 16'h0FFF);
    out_win = (a >= 16'h1000 && a <= 16'h17FF);
    if (wr) begin
      if (a == 16'h0000) begin
        if (d[0]) begin
          if (m_busy) e.err = 1;
          else begin exp_stcp++; m_busy = 1; end
        end
      end else if (a == 16'h0004) begin
        if (d[1]) m_done = 0;
      end else if (a == 16'h0008) begin
        if (m_busy || d > 32'h7FF) e.err = 1;
        else m_bs = d;
      end else if (in_win) begin
        if (m_busy) e.err = 1;
        else begin
          w.sel = 4'(1 << word); w.addr = 7'(line); w.dt = {d, d, d, d};
          wr_q.push_back(w);
        end
      end else begin
        e.err = 1;
      end
    end else begin
      if (a == 16'h0004) e.rdata = m_done * 2 + m_busy;
      else if (a == 16'h0008) e.rdata = m_bs;
      else if (out_win) begin
        if (m_busy) e.err = 1;
        else begin
          rd_q.push_back(7'(line));
          e.rdata = mem[line * 4 + word];
          e.waits = 2;
        end
      end else begin
        e.err = 1;
      end
    end
    exp_q.push_back(e);
    if (done_acc) begin m_busy = 0; m_done = 1; end
    apb(a, wr, d, done_acc);
    chk("byte_size", 128'(oCpByteSize), 128'(m_bs[11:0]));
  endtask

  task automatic done_pulse();
    @(posedge iClk); #1; iCpDone = 1'b1;
    @(posedge iClk); #1; iCpDone = 1'b0;
    m_busy = 0; m_done = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    for (int i = 0; i < 512; i++) mem[i] = $urandom;
    mem[12] = 32'hAAAAAAAA; mem[13] = 32'hBBBBBBBB;
    mem[14] = 32'hCCCCCCCC; mem[15] = 32'hDDDDDDDD;

    repeat (3) @(posedge iClk);
    #1;
    chk("reset_outputs", {61'h0, oPrdata, oPready, oPslverr, oStCp, oCpByteSize, oWrEn_CpInBuf,
                          oWdSel_CpInBuf, oWrAddr_CpInBuf, oRdEn_CpOutBuf, oRdAddr_CpOutBuf}, 128'h0);
    iRsn = 1'b1;

    // load size and one input line
    issue(16'h0008, 1, 32'h10, 0);
    issue(16'h0800, 1, 32'h03020100, 0);
    issue(16'h0804, 1, 32'h07060504, 0);
    issue(16'h0808, 1, 32'h0B0A0908, 0);
    issue(16'h080C, 1, 32'h0F0E0D0C, 0);
    // size boundaries
    issue(16'h0008, 1, 32'h800, 0);
    issue(16'h0008, 1, 32'h7FF, 0);
    issue(16'h0008, 1, 32'h10, 0);
    // start / done / W1C
    issue(16'h0000, 1, 32'h1, 0);
    issue(16'h0004, 0, 32'h0, 0);
    done_pulse();
    issue(16'h0004, 0, 32'h0, 0);
    issue(16'h0004, 1, 32'h2, 0);
    issue(16'h0004, 0, 32'h0, 0);
    // output buffer read with two wait states
    issue(16'h1038, 0, 32'h0, 0);
    // rejections while busy
    issue(16'h0000, 1, 32'h1, 0);
    issue(16'h0800, 1, 32'h12345678, 0);
    issue(16'h0000, 1, 32'h1, 0);
    issue(16'h0008, 1, 32'h800, 0);
    issue(16'h0008, 1, 32'h20, 0);
    issue(16'h1000, 0, 32'h0, 0);
    issue(16'h0008, 0, 32'h0, 0);
    // start collides with completion: rejected, then done
    issue(16'h0000, 1, 32'h1, 1);
    issue(16'h0004, 0, 32'h0, 0);
    // misc error space
    issue(16'h0000, 0, 32'h0, 0);
    issue(16'h0804, 0, 32'h0, 0);
    issue(16'h1004, 1, 32'h5, 0);
    issue(16'h000C, 0, 32'h0, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0: issue(16'h0000, 1, $urandom, 0);
        1: issue(16'h0004, 1'($urandom_range(0, 1)), $urandom, 0);
        2: issue(16'h0008, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 32'hFFF)) : $urandom, 0);
        3, 4: issue(16'(16'h0800 + $urandom_range(0, 2047)), 1'($urandom_range(0, 3) != 0), $urandom, 0);
        5, 6: issue(16'(16'h1000 + $urandom_range(0, 2047)), 1'($urandom_range(0, 3) == 0), $urandom, 0);
        7: begin
          case ($urandom_range(0, 3))
            0: issue(16'h000C, 1'($urandom_range(0, 1)), $urandom, 0);
            1: issue(16'h0002, 1'($urandom_range(0, 1)), $urandom, 0);
            2: issue(16'(16'h1800 + $urandom_range(0, 2047)), 1'($urandom_range(0, 1)), $urandom, 0);
            default: issue(16'(16'h2000 + $urandom_range(0, 16'hDFFF)), 1'($urandom_range(0, 1)), $urandom, 0);
          endcase
        end
        8: if (m_busy) done_pulse();
        default: issue(16'h0004, 0, 32'h0, 0);
      endcase
    end

    // reset lands while an output-buffer read sits in RD_REQ
    if (m_busy) done_pulse();
    issue(16'h0008, 1, 32'h123, 0);
    rd_q.push_back(7'd2);
    @(posedge iClk); #1;
    iPsel = 1'b1; iPenable = 1'b0; iPwrite = 1'b0; iPaddr = 16'h1020;
    @(posedge iClk); #1;
    iPenable = 1'b1;
    @(posedge iClk); #1;
    iRsn = 1'b0;
    #1;
    chk("rst_mid_outputs", {61'h0, oPrdata, oPready, oPslverr, oStCp, oCpByteSize, oWrEn_CpInBuf,
                            oWdSel_CpInBuf, oWrAddr_CpInBuf, oRdEn_CpOutBuf, oRdAddr_CpOutBuf}, 128'h0);
    chk("rst_mid_wrdt", oWrDt_CpInBuf, 128'h0);
    repeat (3) begin
      @(negedge iClk);
      chk("rst_no_pready", 128'(oPready), 128'h0);
    end
    iPsel = 1'b0; iPenable = 1'b0;
    @(posedge iClk); #1;
    iRsn = 1'b1;
    m_busy = 0; m_done = 0; m_bs = 0;
    issue(16'h0008, 0, 32'h0, 0);
    issue(16'h0004, 0, 32'h0, 0);

    repeat (3) @(posedge iClk);
    chk("resp_queue_drained", 128'(exp_q.size()), 128'h0);
    chk("inbuf_queue_drained", 128'(wr_q.size()), 128'h0);
    chk("outbuf_queue_drained", 128'(rd_q.size()), 128'h0);
    chk("stcp_all_seen", 128'(exp_stcp), 128'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
